// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared types and defaults for the boundary-scan register chain
package jtag_pkg;

    typedef enum logic [1:0] {
        BSR_FUNC  = 2'b00,
        BSR_DRIVE = 2'b01,
        BSR_SAFE  = 2'b10,
        BSR_RSVD  = 2'b11
    } bsr_mode_t;

    localparam int                            BSR_WIDTH_DEFAULT = 8;
    localparam logic [BSR_WIDTH_DEFAULT-1:0]  BSR_SAFE_DEFAULT  = '0;

endpackage

// File: rtl/bsr_cell_sync.sv
// rtl/bsr_cell_sync.sv - one boundary-scan cell: shift flop, update flop and pin-side output mux
module bsr_cell_sync
    import jtag_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rst_val,
    input  logic      capture,
    input  logic      shift,
    input  logic      update,
    input  bsr_mode_t mode,
    input  logic      sequential_in,
    input  logic      parallel_in,
    output logic      sequential_out,
    output logic      parallel_out
);

    logic shift_q;
    logic update_q;

    // Shift beats capture; update samples the pre-edge shift value.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= 1'b0;
            update_q <= rst_val;
        end else begin
            if (shift) begin
                shift_q <= sequential_in;
            end else if (capture) begin
                shift_q <= parallel_in;
            end
            if (update) begin
                update_q <= shift_q;
            end
        end
    end

    assign sequential_out = shift_q;

    // rst_val doubles as the clamp value driven in SAFE and reserved modes.
    always_comb begin
        parallel_out = rst_val;
        case (mode)
            BSR_FUNC:  parallel_out = parallel_in;
            BSR_DRIVE: parallel_out = update_q;
            default:   parallel_out = rst_val;
        endcase
    end

endmodule

// File: rtl/bsr_chain.sv
// rtl/bsr_chain.sv - WIDTH-cell boundary-scan register, LSB-first serial order, single clock
module bsr_chain
    import jtag_pkg::*;
#(
    parameter int               WIDTH      = BSR_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  bsr_mode_t        mode,
    input  logic             tdi,
    output logic             tdo,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out
);

    // ser[i] is the shift-stage output of cell i; ser[WIDTH] is the chain input.
    logic [WIDTH:0] ser;

    assign ser[WIDTH] = tdi;
    assign tdo        = ser[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        bsr_cell_sync u_cell (
            .clk            (clk),
            .rst            (rst),
            .rst_val        (SAFE_VALUE[i]),
            .capture        (capture_dr),
            .shift          (shift_dr),
            .update         (update_dr),
            .mode           (mode),
            .sequential_in  (ser[i+1]),
            .parallel_in    (parallel_in[i]),
            .sequential_out (ser[i]),
            .parallel_out   (parallel_out[i])
        );
    end

endmodule

// File: tb/tb_bsr_chain.sv
// tb/tb_bsr_chain.sv - bench for bsr_chain at WIDTH 8, 1 and 33 against a behavioural model
module tb_bsr_chain;
    import jtag_pkg::*;

    localparam logic [7:0]  SV8  = 8'hA5;
    localparam logic [0:0]  SV1  = 1'b1;
    localparam logic [32:0] SV33 = 33'h1_2345_6789;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, capture_dr, shift_dr, update_dr, tdi;
    bsr_mode_t   mode;
    logic [7:0]  pin8,  po8;
    logic [0:0]  pin1,  po1;
    logic [32:0] pin33, po33;
    logic        tdo8, tdo1, tdo33;

    bsr_chain #(.WIDTH(8), .SAFE_VALUE(SV8)) u_w8 (
        .clk(clk), .rst(rst), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .tdi(tdi), .tdo(tdo8),
        .parallel_in(pin8), .parallel_out(po8));

    bsr_chain #(.WIDTH(1), .SAFE_VALUE(SV1)) u_w1 (
        .clk(clk), .rst(rst), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .tdi(tdi), .tdo(tdo1),
        .parallel_in(pin1), .parallel_out(po1));

    bsr_chain #(.WIDTH(33), .SAFE_VALUE(SV33)) u_w33 (
        .clk(clk), .rst(rst), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode(mode), .tdi(tdi), .tdo(tdo33),
        .parallel_in(pin33), .parallel_out(po33));

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] m_sh [3];
    logic [63:0] m_up [3];
    int          wid  [3] = '{8, 1, 33};
    logic [63:0] safev[3] = '{64'(SV8), 64'(SV1), 64'(SV33)};

    function automatic logic [63:0] msk(int k);
        return (64'd1 << wid[k]) - 64'd1;
    endfunction

    function automatic logic [63:0] pin_of(int k);
        case (k)
            0:       return 64'(pin8);
            1:       return 64'(pin1);
            default: return 64'(pin33);
        endcase
    endfunction

    function automatic logic [63:0] po_of(int k);
        case (k)
            0:       return 64'(po8);
            1:       return 64'(po1);
            default: return 64'(po33);
        endcase
    endfunction

    function automatic logic tdo_of(int k);
        case (k)
            0:       return tdo8;
            1:       return tdo1;
            default: return tdo33;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] exp_po;
        for (int k = 0; k < 3; k++) begin
            if (mode == BSR_FUNC)       exp_po = pin_of(k);
            else if (mode == BSR_DRIVE) exp_po = m_up[k];
            else                        exp_po = safev[k];
            chk($sformatf("po_w%0d", wid[k]), po_of(k), exp_po & msk(k));
            chk($sformatf("tdo_w%0d", wid[k]), 64'(tdo_of(k)), 64'(m_sh[k][0]));
        end
    endtask

    // One clock: drive strobes, advance the model with pre-edge values, check after the edge.
    task automatic step(input logic r, input logic c, input logic s, input logic u, input logic t);
        logic [63:0] old;
        rst = r; capture_dr = c; shift_dr = s; update_dr = u; tdi = t;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_sh[k] = '0;
                m_up[k] = safev[k];
            end else begin
                old = m_sh[k];
                if (s)      m_sh[k] = ((m_sh[k] >> 1) | ({63'b0, t} << (wid[k] - 1))) & msk(k);
                else if (c) m_sh[k] = pin_of(k) & msk(k);
                if (u)      m_up[k] = old;
            end
        end
        #1;
        check_model();
    endtask

    task automatic shift_in8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, v[i]);
    endtask

    task automatic set_mode(input bsr_mode_t m);
        mode = m;
        #1;
        check_model();
    endtask

    logic [7:0]  exp_tdo;
    logic [63:0] r64;

    initial begin
        rst = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
        mode = BSR_DRIVE; pin8 = '0; pin1 = '0; pin33 = '0;
        for (int k = 0; k < 3; k++) begin m_sh[k] = '0; m_up[k] = '0; end
        @(negedge clk);

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_po8", 64'(po8), 64'h0A5);
        chk("reset_tdo8", 64'(tdo8), 64'h0);

        // Capture 3C and shift it out LSB first
        pin8 = 8'h3C; pin1 = 1'b1; pin33 = 33'h1_8000_0003;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_tdo = 8'b0011_1100;
        chk("cap_tdo_0", 64'(tdo8), 64'(exp_tdo[0]));
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("cap_tdo_%0d", i), 64'(tdo8), 64'(exp_tdo[i]));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("after_shift_zero", 64'(po8), 64'h0);

        // Preload in FUNC mode, then drive
        set_mode(BSR_FUNC);
        pin8 = 8'hFF; pin1 = 1'b0; pin33 = 33'h0_FFFF_0000;
        shift_in8(8'h96);
        chk("func_transparent", 64'(po8), 64'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("func_after_update", 64'(po8), 64'hFF);
        set_mode(BSR_DRIVE);
        chk("drive_96", 64'(po8), 64'h96);

        // Simultaneous strobes
        shift_in8(8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("simul_update_old", 64'(po8), 64'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("simul_shift_wins", 64'(po8), 64'h80);

        // Safe and reserved clamp
        shift_in8(8'h96);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        set_mode(BSR_SAFE);
        chk("safe_clamp", 64'(po8), 64'hA5);
        set_mode(BSR_RSVD);
        chk("rsvd_clamp", 64'(po8), 64'hA5);
        set_mode(BSR_DRIVE);
        chk("drive_restore", 64'(po8), 64'h96);

        // Reset mid-shift, then a clean shift
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset_po8", 64'(po8), 64'hA5);
        chk("midreset_tdo8", 64'(tdo8), 64'h0);
        shift_in8(8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fresh_shift", 64'(po8), 64'h5A);

        // Randomised traffic on all three widths
        for (int n = 0; n < 800; n++) begin
            r64   = {$urandom, $urandom};
            pin8  = r64[7:0];
            pin1  = r64[8:8];
            pin33 = r64[41:9];
            mode  = bsr_mode_t'(2'($urandom_range(0, 3)));
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
